uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared widths and receiver FSM state type for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_DIV_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a per-frame latched divisor, with a
// single-entry holding register, frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  input  logic                   en,
  input  logic [UART_DIV_W-1:0]  clk_div,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  logic                   s_sin;
  logic                   prev_q;
  uart_state_e            state_q, state_d;
  logic [UART_DIV_W-1:0]  cnt_q, cnt_d;
  logic [UART_DIV_W-1:0]  div_q, div_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   falling;
  logic                   sample;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(sin),
    .q_o(s_sin)
  );

  assign falling = prev_q & ~s_sin;
  assign sample  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (falling) begin
            state_d = StStart;
            div_d   = clk_div;
            // Counter reaches zero exactly clk_div>>1 cycles after the edge.
            cnt_d   = (clk_div >> 1) - UART_DIV_W'(1);
          end
        end
        StStart: begin
          if (sample) begin
            cnt_d   = div_q - UART_DIV_W'(1);
            bit_d   = 3'd0;
            state_d = s_sin ? StIdle : StData;
          end else begin
            cnt_d = cnt_q - UART_DIV_W'(1);
          end
        end
        StData: begin
          if (sample) begin
            shift_d[bit_q] = s_sin;
            cnt_d          = div_q - UART_DIV_W'(1);
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q - UART_DIV_W'(1);
          end
        end
        StStop: begin
          if (sample) begin
            state_d = StIdle;
            done_d  = s_sin;
            ferr_d  = ~s_sin;
          end else begin
            cnt_d = cnt_q - UART_DIV_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Holding register: a completed byte is taken if empty or being drained this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (done_q && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      prev_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      prev_q  <= s_sin;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = done_q & valid_q & ~rx_ready;
  assign busy      = (state_q != StIdle);

endmodule
